// File: rtl/ccl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ccl_pkg                                                      |
// | Description : Shared types for the connected-components first-pass labeller|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package ccl_pkg;

  localparam int CCL_LABEL_W = 8;

  typedef logic [CCL_LABEL_W-1:0] label_t;

  localparam label_t LABEL_BG = '0;

  typedef struct packed {
    label_t hi;
    label_t lo;
  } merge_pair_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    FLATTEN = 2'd2
  } ccl_state_e;

endpackage
`default_nettype wire

// File: rtl/ccl_merge_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ccl_merge_fifo                                               |
// | Description : Power-of-2 FIFO holding label equivalence pairs              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ccl_merge_fifo
  import ccl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_push && !clr) r_mem[r_wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ccl_labeler_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ccl_labeler_p                                                |
// | Description : First-pass CCL labeller with merge FIFO and parent table.    |
// |               Define CCL_FLATTEN_EN to add the path-flattening walk.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ccl_labeler_p
  import ccl_pkg::*;
#(
  parameter int LABEL_W    = 8,
  parameter int MAX_LABELS = 255,
  parameter int MQ_DEPTH   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               sof,
  input  logic               eol,
  input  logic [LABEL_W-1:0] data,
  input  logic [LABEL_W-1:0] A,
  input  logic [LABEL_W-1:0] B,
  input  logic [LABEL_W-1:0] C,
  input  logic [LABEL_W-1:0] D,
  output logic [LABEL_W-1:0] q,
  output logic               q_valid,
  input  logic [LABEL_W-1:0] lkp_label,
  output logic [LABEL_W-1:0] lkp_root,
  output logic               busy,
  output logic               lbl_ovf,
  output logic               mq_drop
);

  localparam int NL_W = LABEL_W + 1;
  localparam int CW   = $clog2(MQ_DEPTH) + 1;
  localparam logic [NL_W-1:0]    C_NL_LAST = NL_W'(MAX_LABELS);
  localparam logic [LABEL_W-1:0] C_BG      = LABEL_W'(LABEL_BG);

  typedef logic [LABEL_W-1:0] lbl_t;
  typedef struct packed {
    lbl_t hi;
    lbl_t lo;
  } pair_t;

  ccl_state_e      r_state;
  lbl_t            r_parent [2**LABEL_W];
  logic [NL_W-1:0] r_next_label;
  logic [CW-1:0]   r_drain_cnt;

  lbl_t          w_nb [4];
  lbl_t          w_min, w_max, w_label, w_lkp;
  logic          w_any, w_act, w_fg, w_new, w_merge, w_alloc;
  pair_t         w_push_pair, w_pop_pair;
  logic          w_mq_full, w_mq_empty;
  logic [CW-1:0] w_mq_count;
  logic          w_drain_step;
  lbl_t          w_r1, w_r2, w_dmax, w_dmin;
  logic          w_we;
  lbl_t          w_waddr, w_wdata;

  assign w_nb[0] = A;
  assign w_nb[1] = B;
  assign w_nb[2] = C;
  assign w_nb[3] = D;

  always_comb begin
    w_any = 1'b0;
    w_min = '1;
    w_max = C_BG;
    for (int k = 0; k < 4; k++) begin
      if (w_nb[k] != C_BG) begin
        w_any = 1'b1;
        if (w_nb[k] < w_min) w_min = w_nb[k];
        if (w_nb[k] > w_max) w_max = w_nb[k];
      end
    end
  end

  // sof swallows any pixel presented in the same cycle
  assign w_act   = en & ~sof;
  assign w_fg    = (data != C_BG);
  assign w_new   = w_act & w_fg & ~w_any;
  assign w_merge = w_act & w_fg & w_any & (w_min != w_max);
  assign w_alloc = w_new & (r_next_label <= C_NL_LAST);
  assign w_label = (!w_act || !w_fg) ? C_BG :
                   (!w_any ? (w_alloc ? r_next_label[LABEL_W-1:0] : C_BG) : w_min);
  assign w_push_pair = {w_max, w_min};

  ccl_merge_fifo #(
    .WIDTH (2*LABEL_W),
    .DEPTH (MQ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (sof),
    .push    (w_merge),
    .pop     (w_drain_step),
    .din     (w_push_pair),
    .dout    (w_pop_pair),
    .full    (w_mq_full),
    .empty   (w_mq_empty),
    .count   (w_mq_count)
  );

  assign w_r1   = (w_pop_pair.hi == C_BG) ? C_BG : r_parent[w_pop_pair.hi];
  assign w_r2   = (w_pop_pair.lo == C_BG) ? C_BG : r_parent[w_pop_pair.lo];
  assign w_dmax = (w_r1 > w_r2) ? w_r1 : w_r2;
  assign w_dmin = (w_r1 > w_r2) ? w_r2 : w_r1;
  assign w_drain_step = (r_state == DRAIN) & ~sof & ~w_alloc & ~w_mq_empty;
  assign w_lkp  = (lkp_label == C_BG) ? C_BG : r_parent[lkp_label];
  assign busy   = (r_state != IDLE);

`ifdef CCL_FLATTEN_EN
  lbl_t r_fl_idx;
  logic r_fl_chg;
  lbl_t w_fl_p, w_fl_pp;
  logic w_fl_live, w_fl_upd, w_fl_last;

  assign w_fl_p    = (r_fl_idx == C_BG) ? C_BG : r_parent[r_fl_idx];
  assign w_fl_pp   = (w_fl_p == C_BG) ? C_BG : r_parent[w_fl_p];
  assign w_fl_live = (r_state == FLATTEN) & ~sof & ~w_alloc & ({1'b0, r_fl_idx} < r_next_label);
  assign w_fl_upd  = w_fl_live & (w_fl_pp != w_fl_p);
  assign w_fl_last = ({1'b0, r_fl_idx} == r_next_label - 1'b1);
`endif

  // Single table write port: allocation first, then drain, then flatten
  always_comb begin
    w_we    = 1'b0;
    w_waddr = C_BG;
    w_wdata = C_BG;
    if (w_alloc) begin
      w_we    = 1'b1;
      w_waddr = r_next_label[LABEL_W-1:0];
      w_wdata = r_next_label[LABEL_W-1:0];
    end else if (w_drain_step && (w_r1 != w_r2)) begin
      w_we    = 1'b1;
      w_waddr = w_dmax;
      w_wdata = w_dmin;
    end
`ifdef CCL_FLATTEN_EN
    else if (w_fl_upd) begin
      w_we    = 1'b1;
      w_waddr = r_fl_idx;
      w_wdata = w_fl_pp;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_we) r_parent[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_drain_cnt  <= '0;
      r_next_label <= NL_W'(1);
      lbl_ovf      <= 1'b0;
      mq_drop      <= 1'b0;
      q            <= C_BG;
      q_valid      <= 1'b0;
      lkp_root     <= C_BG;
`ifdef CCL_FLATTEN_EN
      r_fl_idx     <= LABEL_W'(1);
      r_fl_chg     <= 1'b0;
`endif
    end else begin
      q        <= w_label;
      q_valid  <= w_act;
      lkp_root <= w_lkp;
      if (sof) begin
        r_state      <= IDLE;
        r_drain_cnt  <= '0;
        r_next_label <= NL_W'(1);
        lbl_ovf      <= 1'b0;
        mq_drop      <= 1'b0;
      end else begin
        if (w_alloc)             r_next_label <= r_next_label + 1'b1;
        if (w_new && !w_alloc)   lbl_ovf      <= 1'b1;
        if (w_merge && w_mq_full) mq_drop     <= 1'b1;
        case (r_state)
          IDLE: begin
            if (eol) begin
              if (w_mq_count != '0) begin
                r_state     <= DRAIN;
                r_drain_cnt <= w_mq_count;
              end
`ifdef CCL_FLATTEN_EN
              else begin
                r_state  <= FLATTEN;
                r_fl_idx <= LABEL_W'(1);
                r_fl_chg <= 1'b0;
              end
`endif
            end
          end
          DRAIN: begin
            if (w_drain_step) begin
              r_drain_cnt <= r_drain_cnt - 1'b1;
              if (r_drain_cnt == CW'(1)) begin
`ifdef CCL_FLATTEN_EN
                r_state  <= FLATTEN;
                r_fl_idx <= LABEL_W'(1);
                r_fl_chg <= 1'b0;
`else
                r_state  <= IDLE;
`endif
              end
            end
          end
`ifdef CCL_FLATTEN_EN
          FLATTEN: begin
            if (!w_alloc) begin
              if (!w_fl_live) begin
                r_state <= IDLE;
              end else if (w_fl_last) begin
                // Repeat the walk until one full pass changes nothing
                if (r_fl_chg || w_fl_upd) begin
                  r_fl_idx <= LABEL_W'(1);
                  r_fl_chg <= 1'b0;
                end else begin
                  r_state <= IDLE;
                end
              end else begin
                r_fl_idx <= r_fl_idx + 1'b1;
                if (w_fl_upd) r_fl_chg <= 1'b1;
              end
            end
          end
`endif
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccl_labeler_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ccl_labeler_p                                             |
// | Description : Directed scoreboard bench for ccl_labeler_p                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_ccl_labeler_p;

  localparam int LW = 8;
  localparam int ML = 255;
  localparam int MQ = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0, sof = 1'b0, eol = 1'b0;
  logic [LW-1:0] data = '0, A = '0, B = '0, C = '0, D = '0, lkp_label = '0;
  logic [LW-1:0] q, lkp_root;
  logic          q_valid, busy, lbl_ovf, mq_drop;

  int            checks = 0;
  int            errors = 0;
  logic [LW-1:0] sb [$];
  logic [LW-1:0] exp_q;

  ccl_labeler_p #(.LABEL_W(LW), .MAX_LABELS(ML), .MQ_DEPTH(MQ)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .sof(sof), .eol(eol), .data(data),
    .A(A), .B(B), .C(C), .D(D), .q(q), .q_valid(q_valid),
    .lkp_label(lkp_label), .lkp_root(lkp_root), .busy(busy),
    .lbl_ovf(lbl_ovf), .mq_drop(mq_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every valid output pops the oldest expected label
  always @(negedge clk) begin
    if (reset_n && q_valid) begin
      if (sb.size() == 0) chk("q_unexpected", 32'(q), 32'hFFFF_FFFF);
      else begin
        exp_q = sb.pop_front();
        chk("q", 32'(q), 32'(exp_q));
      end
    end
  end

  task automatic drive(input logic [LW-1:0] d, a, b, c, w, ex);
    en = 1'b1; data = d; A = a; B = b; C = c; D = w;
    sb.push_back(ex);
  endtask

  task automatic pix(input logic [LW-1:0] d, a, b, c, w, ex);
    @(negedge clk);
    drive(d, a, b, c, w, ex);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0; eol = 1'b0; sof = 1'b0;
    end
  endtask

  task automatic pulse_eol();
    @(negedge clk); en = 1'b0; eol = 1'b1;
    @(negedge clk); eol = 1'b0;
  endtask

  task automatic pulse_sof();
    @(negedge clk); en = 1'b0; sof = 1'b1;
    @(negedge clk); sof = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk); en = 1'b0; n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(2);
    chk("rst_q", 32'(q), 0);
    chk("rst_qv", 32'(q_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(lbl_ovf), 0);
    chk("rst_drop", 32'(mq_drop), 0);
    chk("rst_lkp", 32'(lkp_root), 0);
    chk("rst_next", 32'(dut.r_next_label), 1);
    chk("rst_cnt", 32'(dut.w_mq_count), 0);
    reset_n = 1'b1;

    // New labels 1..3, then 4 and 5 for the merge test
    pix(1, 0, 0, 0, 0, 1);
    pix(1, 0, 0, 0, 0, 2);
    pix(1, 0, 0, 0, 0, 3);
    idle(1);
    chk("t1_next", 32'(dut.r_next_label), 4);
    pix(1, 0, 0, 0, 0, 4);
    pix(1, 0, 0, 0, 0, 5);

    // Merge B=2,D=5, copy, background
    pix(1, 0, 2, 0, 5, 2);
    idle(1);
    chk("t2_cnt", 32'(dut.w_mq_count), 1);
    pix(1, 2, 2, 0, 2, 2);
    pix(0, 2, 5, 0, 0, 0);
    idle(1);
    chk("t2_cnt_copy", 32'(dut.w_mq_count), 1);
    pulse_eol();
`ifndef CCL_FLATTEN_EN
    chk("t2_busy_on", 32'(busy), 1);
    idle(1);
    chk("t2_busy_off", 32'(busy), 0);
`endif
    wait_idle();
    lkp_label = 5; idle(1);
    chk("t2_lkp5", 32'(lkp_root), 2);
    lkp_label = 0; idle(1);
    chk("t2_lkp0", 32'(lkp_root), 0);
    lkp_label = 4; idle(1);
    chk("t2_lkp4", 32'(lkp_root), 4);

    // Overfill merge FIFO, drain exactly MQ pairs
    for (int i = 0; i < MQ + 1; i++) pix(1, 0, 1, 0, 3, 1);
    idle(1);
    chk("t3_cnt_full", 32'(dut.w_mq_count), MQ);
    chk("t3_drop", 32'(mq_drop), 1);
    pulse_eol();
    idle(MQ - 1);
    chk("t3_cnt_last", 32'(dut.w_mq_count), 1);
    idle(1);
    chk("t3_cnt_done", 32'(dut.w_mq_count), 0);
    wait_idle();
    lkp_label = 3; idle(1);
    chk("t3_lkp3", 32'(lkp_root), 1);
    chk("t3_drop_sticky", 32'(mq_drop), 1);
    pulse_sof();
    chk("t3_drop_clr", 32'(mq_drop), 0);
    chk("t3_next_clr", 32'(dut.r_next_label), 1);
    chk("t3_cnt_clr", 32'(dut.w_mq_count), 0);

    // Label exhaustion
    for (int i = 1; i <= ML; i++) pix(1, 0, 0, 0, 0, LW'(i));
    idle(1);
    chk("t4_next_full", 32'(dut.r_next_label), ML + 1);
    chk("t4_ovf_pre", 32'(lbl_ovf), 0);
    pix(1, 0, 0, 0, 0, 0);
    idle(1);
    chk("t4_ovf", 32'(lbl_ovf), 1);
    chk("t4_next_hold", 32'(dut.r_next_label), ML + 1);
    pulse_sof();
    chk("t4_ovf_clr", 32'(lbl_ovf), 0);
    chk("t4_next_clr", 32'(dut.r_next_label), 1);
    pix(1, 0, 0, 0, 0, 1);

    // Allocation during DRAIN stalls the drain
    pix(1, 0, 0, 0, 0, 2);
    pix(1, 0, 0, 0, 0, 3);
    pix(1, 0, 0, 0, 0, 4);
    for (int i = 0; i < 4; i++) pix(1, 0, 2, 0, 1, 1);
    idle(1);
    chk("t5_cnt", 32'(dut.w_mq_count), 4);
    pulse_eol();
    drive(1, 0, 0, 0, 0, 5);
    idle(1);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_cnt_stall", 32'(dut.w_mq_count), 4);
    lkp_label = 5; idle(1);
    chk("t5_lkp_alloc", 32'(lkp_root), 5);
    chk("t5_cnt_resume", 32'(dut.w_mq_count), 3);
    wait_idle();

    // Chained merges across two rows
    pulse_sof();
    pix(1, 0, 0, 0, 0, 1);
    pix(1, 0, 0, 0, 0, 2);
    pix(1, 0, 0, 0, 0, 3);
    pix(1, 0, 3, 0, 2, 2);
    pulse_eol();
    wait_idle();
    pix(1, 0, 2, 0, 1, 1);
    pulse_eol();
    wait_idle();
    lkp_label = 3; idle(1);
`ifdef CCL_FLATTEN_EN
    chk("t6_lkp3", 32'(lkp_root), 1);
`else
    chk("t6_lkp3", 32'(lkp_root), 2);
`endif
    lkp_label = 2; idle(1);
    chk("t6_lkp2", 32'(lkp_root), 1);

    // Async reset in the middle of a drain
    for (int i = 0; i < 3; i++) pix(1, 0, 3, 0, 1, 1);
    pulse_eol();
    chk("t7_busy_pre", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_busy_rst", 32'(busy), 0);
    chk("t7_qv_rst", 32'(q_valid), 0);
    @(negedge clk); reset_n = 1'b1;
    chk("t7_next_rst", 32'(dut.r_next_label), 1);
    chk("t7_cnt_rst", 32'(dut.w_mq_count), 0);

    idle(2);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
